ip_codma_mem_responder: RTL and testbench

- Memory-side responder for the CODMA bus: the target that the DMA read and write machines talk to.
- Accepts single-beat and burst read/write requests, serves them from an internal 64-bit word array, and signals bus errors.
- Used as the on-chip scratch/descriptor memory and as the bus model in block-level benches.

---
 rtl/ip_codma_mem_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_ip_codma_mem_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_mem_responder.sv
// CODMA memory-side responder: single/burst read and write target backed by a
// 64-bit word array, with request checking and one-cycle bus error pulses.
// Optional feature macro: CODMA_MEM_ERR_INJECT_EN (adds err_inject_i to abort
// bursts and fault requests on demand).
module ip_codma_mem_responder #(
  parameter int unsigned DEPTH      = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  size_i,
  output logic        gnt_o,
  output logic [63:0] rdata_o,
  output logic        rvalid_o,
  output logic        rlast_o,
  input  logic [63:0] wdata_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic        wdone_o,
  output logic        error_o,
  output logic        busy_o
`ifdef CODMA_MEM_ERR_INJECT_EN
  ,
  input  logic        err_inject_i
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [33:0] SPAN     = 34'(DEPTH) << 3;
  localparam logic [3:0]  LAT_INIT = (RD_LATENCY >= 2) ? 4'(RD_LATENCY - 2) : 4'd0;
  localparam bit          LAT_ONE  = (RD_LATENCY == 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_WAIT  = 3'd1,
    S_RD_BURST = 3'd2,
    S_WR_BURST = 3'd3,
    S_ERR      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    lat_q, lat_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          wdone_q, wdone_d;

  logic [63:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] fetch_idx;

  logic          inject;
  logic          size_ok;
  logic          in_range;
  logic          req_any;
  logic          req_fault;
  logic          req_ok;
  logic [1:0]    req_last;
  logic [33:0]   first_off;
  logic [33:0]   last_off;
  logic [AW-1:0] req_idx;
  logic          wr_acc;

`ifdef CODMA_MEM_ERR_INJECT_EN
  assign inject = err_inject_i;
`else
  assign inject = 1'b0;
`endif

  // Decode and validate the request presented on the bus this cycle
  always_comb begin
    size_ok  = 1'b1;
    req_last = 2'd0;
    case (size_i)
      4'd3:    req_last = 2'd0;
      4'd8:    req_last = 2'd1;
      4'd9:    req_last = 2'd3;
      default: size_ok  = 1'b0;
    endcase
    // 34-bit offsets: addresses below BASE_ADDR or past the array land >= SPAN
    first_off = {2'b00, addr_i} - {2'b00, BASE_ADDR};
    last_off  = first_off + {29'd0, req_last, 3'b000};
    in_range  = (first_off < SPAN) && (last_off < SPAN);
    req_idx   = first_off[AW+2:3];
    req_any   = read_i | write_i;
    req_fault = (read_i & write_i) | ~size_ok | (addr_i[2:0] != 3'b000) |
                ~in_range | inject;
    req_ok    = req_any & ~req_fault;
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (req_fault) begin
            state_d = S_ERR;
          end else if (write_i) begin
            state_d = S_WR_BURST;
          end else if (LAT_ONE) begin
            state_d = S_RD_BURST;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = S_RD_BURST;
        end
      end
      S_RD_BURST: begin
        if (inject) begin
          state_d = S_ERR;
        end else if (beat_q == last_q) begin
          state_d = S_IDLE;
        end
      end
      S_WR_BURST: begin
        if (inject) begin
          state_d = S_ERR;
        end else if (wvalid_i && (beat_q == last_q)) begin
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; injection drops rvalid/wready in the aborting cycle
  always_comb begin
    gnt_o    = 1'b0;
    rvalid_o = 1'b0;
    rlast_o  = 1'b0;
    wready_o = 1'b0;
    error_o  = 1'b0;
    busy_o   = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:     gnt_o = req_ok;
      S_RD_BURST: begin
        rvalid_o = ~inject;
        rlast_o  = ~inject & (beat_q == last_q);
      end
      S_WR_BURST: wready_o = ~inject;
      S_ERR:      error_o  = 1'b1;
      default:    ;
    endcase
  end

  assign rdata_o = rdata_q;
  assign wdone_o = wdone_q;
  assign wr_acc  = (state_q == S_WR_BURST) & wvalid_i & ~inject;

  // Burst bookkeeping, read prefetch into rdata and write strobe
  always_comb begin
    beat_d    = beat_q;
    last_d    = last_q;
    lat_d     = lat_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    wdone_d   = 1'b0;
    mem_we    = 1'b0;
    fetch_idx = ptr_q;

    if ((state_q == S_IDLE) && req_ok) begin
      beat_d    = 2'd0;
      last_d    = req_last;
      lat_d     = LAT_INIT;
      ptr_d     = req_idx;
      fetch_idx = req_idx;
    end

    if ((state_q == S_RD_WAIT) && (lat_q != 4'd0)) begin
      lat_d = lat_q - 4'd1;
    end

    if (state_q == S_RD_BURST) begin
      beat_d = beat_q + 2'd1;
    end

    // Beat data is registered one cycle ahead of the beat it belongs to
    if (state_d == S_RD_BURST) begin
      rdata_d = mem_q[fetch_idx];
      ptr_d   = fetch_idx + AW'(1);
    end

    if (wr_acc) begin
      mem_we = 1'b1;
      ptr_d  = ptr_q + AW'(1);
      beat_d = beat_q + 2'd1;
      if (beat_q == last_q) begin
        wdone_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_q  <= 2'd0;
      last_q  <= 2'd0;
      lat_q   <= 4'd0;
      ptr_q   <= '0;
      rdata_q <= 64'd0;
      wdone_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      last_q  <= last_d;
      lat_q   <= lat_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      wdone_q <= wdone_d;
    end
  end

  // Word array; contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[ptr_q] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// Scoreboard bench for ip_codma_mem_responder: main instance (RD_LATENCY=2)
// plus RD_LATENCY=1 and RD_LATENCY=15 instances sharing the same stimulus.
module tb_ip_codma_mem_responder;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } rd_exp_t;

  logic        clk;
  logic        rst_n;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  size;
  logic [63:0] wdata;
  logic        wvalid;
  logic        err_inject;

  logic        gnt_m, rvalid_m, rlast_m, wready_m, wdone_m, error_m, busy_m;
  logic [63:0] rdata_m;
  logic        gnt_a, rvalid_a, rlast_a, wready_a, wdone_a, error_a, busy_a;
  logic [63:0] rdata_a;
  logic        gnt_b, rvalid_b, rlast_b, wready_b, wdone_b, error_b, busy_b;
  logic [63:0] rdata_b;

  int          n_checks;
  int          n_fail;
  rd_exp_t     sb [$];
  logic [63:0] model [256];
  rd_exp_t     mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ip_codma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .RD_LATENCY(2)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .read_i(read), .write_i(write),
    .addr_i(addr), .size_i(size), .gnt_o(gnt_m), .rdata_o(rdata_m),
    .rvalid_o(rvalid_m), .rlast_o(rlast_m), .wdata_i(wdata), .wvalid_i(wvalid),
    .wready_o(wready_m), .wdone_o(wdone_m), .error_o(error_m), .busy_o(busy_m)
`ifdef CODMA_MEM_ERR_INJECT_EN
    , .err_inject_i(err_inject)
`endif
  );

  ip_codma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .RD_LATENCY(1)) u_lat1 (
    .clk_i(clk), .reset_n_i(rst_n), .read_i(read), .write_i(write),
    .addr_i(addr), .size_i(size), .gnt_o(gnt_a), .rdata_o(rdata_a),
    .rvalid_o(rvalid_a), .rlast_o(rlast_a), .wdata_i(wdata), .wvalid_i(wvalid),
    .wready_o(wready_a), .wdone_o(wdone_a), .error_o(error_a), .busy_o(busy_a)
`ifdef CODMA_MEM_ERR_INJECT_EN
    , .err_inject_i(err_inject)
`endif
  );

  ip_codma_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .RD_LATENCY(15)) u_lat15 (
    .clk_i(clk), .reset_n_i(rst_n), .read_i(read), .write_i(write),
    .addr_i(addr), .size_i(size), .gnt_o(gnt_b), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .rlast_o(rlast_b), .wdata_i(wdata), .wvalid_i(wvalid),
    .wready_o(wready_b), .wdone_o(wdone_b), .error_o(error_b), .busy_o(busy_b)
`ifdef CODMA_MEM_ERR_INJECT_EN
    , .err_inject_i(err_inject)
`endif
  );

  // Count one comparison and report it if it mismatches
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nb(input logic [3:0] s);
    case (s)
      4'd8:    return 2;
      4'd9:    return 4;
      default: return 1;
    endcase
  endfunction

  // Scoreboard pop on every main-instance read beat
  always @(negedge clk) begin
    if (rvalid_m === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 64'(rvalid_m), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_data", rdata_m, mon_e.data);
        check("rd_last", 64'(rlast_m), 64'(mon_e.last));
      end
    end
  end

  // Write burst; optional stall after beat stall_after, optional inject on beat inject_beat
  task automatic do_write(input logic [31:0] a, input logic [3:0] s, input logic [63:0] d [4],
                          input int stall_after, input int stall_len, input int inject_beat);
    int n;
    int idx;
    n     = nb(s);
    idx   = int'(a >> 3);
    write = 1'b1;
    addr  = a;
    size  = s;
    @(negedge clk);
    check("wr_gnt", 64'(gnt_m), 64'd1);
    check("wr_gnt_not_busy", 64'(busy_m), 64'd0);
    @(posedge clk); #1;
    write = 1'b0;
    for (int k = 0; k < n; k++) begin
      if ((stall_after >= 0) && (k == stall_after + 1)) begin
        for (int st = 0; st < stall_len; st++) begin
          wvalid = 1'b0;
          @(negedge clk);
          check("wr_stall_ready", 64'(wready_m), 64'd1);
          check("wr_stall_nodone", 64'(wdone_m), 64'd0);
          @(posedge clk); #1;
        end
      end
      wvalid = 1'b1;
      wdata  = d[k];
      if (k == inject_beat) begin
        err_inject = 1'b1;
        @(negedge clk);
        check("inj_ready_drop", 64'(wready_m), 64'd0);
        @(posedge clk); #1;
        err_inject = 1'b0;
        wvalid     = 1'b0;
        @(negedge clk);
        check("inj_error", 64'(error_m), 64'd1);
        check("inj_nodone", 64'(wdone_m), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("inj_nodone2", 64'(wdone_m), 64'd0);
        check("inj_idle", 64'(busy_m), 64'd0);
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      check("wr_ready", 64'(wready_m), 64'd1);
      check("wr_nodone_early", 64'(wdone_m), 64'd0);
      @(posedge clk); #1;
      model[idx + k] = d[k];
    end
    wvalid = 1'b0;
    @(negedge clk);
    check("wr_done", 64'(wdone_m), 64'd1);
    check("wr_idle", 64'(busy_m), 64'd0);
    check("wr_ready_low", 64'(wready_m), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_done_pulse", 64'(wdone_m), 64'd0);
    @(posedge clk); #1;
  endtask

  // Read burst; expected beats go to the scoreboard, latency checked on all instances
  task automatic do_read(input logic [31:0] a, input logic [3:0] s);
    int      n;
    int      idx;
    int      f_m;
    int      f_a;
    int      f_b;
    int      b_a;
    int      b_b;
    bit      done;
    rd_exp_t e;
    n    = nb(s);
    idx  = int'(a >> 3);
    f_m  = -1;
    f_a  = -1;
    f_b  = -1;
    b_a  = 0;
    b_b  = 0;
    done = 1'b0;
    for (int k = 0; k < n; k++) begin
      e.data = model[idx + k];
      e.last = (k == n - 1);
      sb.push_back(e);
    end
    read = 1'b1;
    addr = a;
    size = s;
    @(negedge clk);
    check("rd_gnt", 64'(gnt_m), 64'd1);
    check("rd_gnt_lat1", 64'(gnt_a), 64'd1);
    check("rd_gnt_lat15", 64'(gnt_b), 64'd1);
    @(posedge clk); #1;
    read = 1'b0;
    for (int c = 1; (c <= 40) && !done; c++) begin
      @(negedge clk);
      if (rvalid_m && (f_m < 0)) f_m = c;
      if (rvalid_a) begin
        if (f_a < 0) f_a = c;
        b_a++;
      end
      if (rvalid_b) begin
        if (f_b < 0) f_b = c;
        b_b++;
      end
      if (!busy_m && !busy_a && !busy_b) done = 1'b1;
      @(posedge clk); #1;
    end
    check("rd_complete", 64'(done), 64'd1);
    check("rd_first_lat2", 64'(f_m), 64'd2);
    check("rd_first_lat1", 64'(f_a), 64'd1);
    check("rd_first_lat15", 64'(f_b), 64'd15);
    check("rd_beats_lat1", 64'(b_a), 64'(n));
    check("rd_beats_lat15", 64'(b_b), 64'(n));
    check("rd_hold", rdata_m, model[idx + n - 1]);
    check("rd_hold_lat1", rdata_a, model[idx + n - 1]);
    check("rd_hold_lat15", rdata_b, model[idx + n - 1]);
    check("rd_rvalid_low", 64'(rvalid_m), 64'd0);
    check("rd_sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Illegal request held for 2*reps cycles: error every other cycle, never a grant
  task automatic do_bad(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] s, input int reps);
    read  = rd;
    write = wr;
    addr  = a;
    size  = s;
    for (int c = 0; c < 2 * reps; c++) begin
      @(negedge clk);
      check("bad_no_gnt", 64'(gnt_m), 64'd0);
      check("bad_error", 64'(error_m), 64'((c % 2) == 1));
      check("bad_no_wready", 64'(wready_m), 64'd0);
      @(posedge clk); #1;
    end
    read  = 1'b0;
    write = 1'b0;
    @(negedge clk);
    check("bad_error_clear", 64'(error_m), 64'd0);
    check("bad_idle", 64'(busy_m), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    addr       = 32'd0;
    size       = 4'd0;
    wdata      = 64'd0;
    wvalid     = 1'b0;
    err_inject = 1'b0;
    #3;
    check("rst_gnt", 64'(gnt_m), 64'd0);
    check("rst_rdata", rdata_m, 64'd0);
    check("rst_rvalid", 64'(rvalid_m), 64'd0);
    check("rst_rlast", 64'(rlast_m), 64'd0);
    check("rst_wready", 64'(wready_m), 64'd0);
    check("rst_wdone", 64'(wdone_m), 64'd0);
    check("rst_error", 64'(error_m), 64'd0);
    check("rst_busy", 64'(busy_m), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write then read
    do_write(32'h10, 4'd3, '{64'hDEAD_BEEF_00C0_FFEE, 64'd0, 64'd0, 64'd0}, -1, 0, -1);
    do_read(32'h10, 4'd3);

    // 4-beat burst with a 3-cycle stall after beat 2, then read back
    do_write(32'h40, 4'd9, '{64'd1, 64'd2, 64'd3, 64'd4}, 1, 3, -1);
    do_read(32'h40, 4'd9);

    // 2-beat burst and the last legal word
    do_write(32'h20, 4'd8, '{64'hA5A5_0000_1111_2222, 64'h5A5A_3333_4444_5555, 64'd0, 64'd0}, -1, 0, -1);
    do_read(32'h20, 4'd8);
    do_write(32'h7F8, 4'd3, '{64'hCAFE_F00D_1234_5678, 64'd0, 64'd0, 64'd0}, -1, 0, -1);
    do_read(32'h7F8, 4'd3);

    // illegal requests
    do_bad(1'b1, 1'b0, 32'h10, 4'd5, 1);
    do_bad(1'b1, 1'b0, 32'h0C, 4'd3, 1);
    do_bad(1'b1, 1'b0, 32'h7F8, 4'd9, 1);
    do_bad(1'b0, 1'b1, 32'h7F8, 4'd8, 1);
    do_bad(1'b0, 1'b1, 32'h800, 4'd3, 1);
    do_bad(1'b1, 1'b1, 32'h10, 4'd3, 2);

    // reset in the middle of a 4-beat read
    do_write(32'h0, 4'd9, '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444}, -1, 0, -1);
    mon_e.data = model[0];
    mon_e.last = 1'b0;
    sb.push_back(mon_e);
    read = 1'b1;
    addr = 32'h0;
    size = 4'd9;
    @(negedge clk);
    check("rst_rd_gnt", 64'(gnt_m), 64'd1);
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    check("rst_rd_wait", 64'(rvalid_m), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_rd_beat1", 64'(rvalid_m), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(rvalid_m), 64'd0);
    check("rst_mid_rlast", 64'(rlast_m), 64'd0);
    check("rst_mid_rdata", rdata_m, 64'd0);
    check("rst_mid_busy", 64'(busy_m), 64'd0);
    check("rst_mid_rvalid_lat1", 64'(rvalid_a), 64'd0);
    check("rst_mid_busy_lat15", 64'(busy_b), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_quiet_rvalid", 64'(rvalid_m), 64'd0);
      check("rst_quiet_wdone", 64'(wdone_m), 64'd0);
      @(posedge clk); #1;
    end
    check("rst_sb_drained", 64'(sb.size()), 64'd0);
    do_read(32'h0, 4'd9);

`ifdef CODMA_MEM_ERR_INJECT_EN
    // abort a write on beat 3: beats 1-2 land, beats 3-4 keep old contents
    do_write(32'h80, 4'd9, '{64'hA0, 64'hA1, 64'hA2, 64'hA3}, -1, 0, -1);
    do_write(32'h80, 4'd9, '{64'hB0, 64'hB1, 64'hB2, 64'hB3}, -1, 0, 2);
    check("inj_model_beat3", model[18], 64'hA2);
    do_read(32'h80, 4'd9);
    // injection turns a valid request into a fault
    err_inject = 1'b1;
    do_bad(1'b1, 1'b0, 32'h10, 4'd3, 1);
    err_inject = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
